// File: rtl/rv32_mc_ctrl_if.sv
// Shared instruction/data memory handshake between the RV32I multi-cycle
// controller (master) and the memory (slave).
interface rv32_mc_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/rv32_mc_ctrl.sv
// Multi-cycle main control FSM for an RV32I datapath with a retired-instruction counter.
// Optional macro RV32_MC_ILLEGAL_TRAP_EN: unknown opcodes halt and raise a sticky illegal flag.
module rv32_mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  rv32_mc_ctrl_if.master       mem,
  input  logic [31:0]          ir,
  input  logic                 br_taken,
  output logic                 ir_we,
  output logic                 ab_we,
  output logic                 alu_a_sel,
  output logic                 alu_b_sel,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 halted,
  output logic [CNT_W-1:0]     instret
`ifdef RV32_MC_ILLEGAL_TRAP_EN
  ,
  output logic                 illegal
`endif
);

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_OP,
    C_OPIMM,
    C_LUI,
    C_AUIPC,
    C_LOAD,
    C_STORE,
    C_JAL,
    C_JALR,
    C_BRANCH,
    C_FENCE,
    C_SYSTEM,
    C_UNKNOWN
  } op_class_e;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_MEM   = 2'd1;
  localparam logic [1:0] WB_PC4   = 2'd2;
  localparam logic [1:0] WB_IMM   = 2'd3;

  state_e    state, next_state;
  op_class_e op_class;
  logic      retire;
  logic      rd_nz;
  logic      funct3_zero;
  logic      ir_unused;

  assign rd_nz       = (ir[11:7] != 5'd0);
  assign funct3_zero = (ir[14:12] == 3'd0);
  assign ir_unused   = ^ir[31:15];

  always_comb begin
    unique case (ir[6:0])
      7'b0110011: op_class = C_OP;
      7'b0010011: op_class = C_OPIMM;
      7'b0110111: op_class = C_LUI;
      7'b0010111: op_class = C_AUIPC;
      7'b0000011: op_class = C_LOAD;
      7'b0100011: op_class = C_STORE;
      7'b1101111: op_class = C_JAL;
      7'b1100111: op_class = C_JALR;
      7'b1100011: op_class = C_BRANCH;
      7'b0001111: op_class = C_FENCE;
      7'b1110011: op_class = C_SYSTEM;
      default:    op_class = C_UNKNOWN;
    endcase
  end

`ifdef RV32_MC_ILLEGAL_TRAP_EN
  logic set_illegal;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RESET;
      instret <= '0;
`ifdef RV32_MC_ILLEGAL_TRAP_EN
      illegal <= 1'b0;
`endif
    end else begin
      state <= next_state;
      if (retire) instret <= instret + CNT_W'(1);
`ifdef RV32_MC_ILLEGAL_TRAP_EN
      if (set_illegal) illegal <= 1'b1;
`endif
    end
  end

  // NOTE: every output and next_state gets a default before the case so no
  // path through the block leaves a variable unassigned (no latches).
  always_comb begin
    next_state    = state;
    retire        = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.addr_sel  = 1'b0;
    ir_we         = 1'b0;
    ab_we         = 1'b0;
    alu_a_sel     = 1'b0;
    alu_b_sel     = 1'b0;
    pc_we         = 1'b0;
    pc_sel        = PC_PLUS4;
    rf_we         = 1'b0;
    wb_sel        = WB_ALU;
    halted        = 1'b0;
`ifdef RV32_MC_ILLEGAL_TRAP_EN
    set_illegal   = 1'b0;
`endif

    unique case (state)
      S_RESET: next_state = S_FETCH;

      S_FETCH: begin
        mem.mem_req = 1'b1;
        if (mem.mem_ready) begin
          ir_we      = 1'b1;
          next_state = S_DECODE;
        end
      end

      S_DECODE: begin
        ab_we      = 1'b1;
        next_state = S_EXEC;
      end

      S_EXEC: begin
        unique case (op_class)
          C_OP: next_state = S_WB;
          C_OPIMM: begin
            alu_b_sel  = 1'b1;
            next_state = S_WB;
          end
          C_LUI: next_state = S_WB;
          C_AUIPC: begin
            alu_a_sel  = 1'b1;
            alu_b_sel  = 1'b1;
            next_state = S_WB;
          end
          C_LOAD, C_STORE: begin
            alu_b_sel  = 1'b1;
            next_state = S_MEM;
          end
          C_JAL, C_JALR: begin
            alu_b_sel  = 1'b1;
            next_state = S_WB;
          end
          C_BRANCH: begin
            pc_we      = 1'b1;
            pc_sel     = br_taken ? PC_IMM : PC_PLUS4;
            retire     = 1'b1;
            next_state = S_FETCH;
          end
          C_FENCE: begin
            pc_we      = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
          end
          C_SYSTEM: begin
            retire = 1'b1;
            if (funct3_zero) begin
              // ECALL/EBREAK retire without touching the PC.
              next_state = S_HALT;
            end else begin
              pc_we      = 1'b1;
              next_state = S_FETCH;
            end
          end
          default: begin
`ifdef RV32_MC_ILLEGAL_TRAP_EN
            set_illegal = 1'b1;
            next_state  = S_HALT;
`else
            pc_we      = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
`endif
          end
        endcase
      end

      S_MEM: begin
        mem.mem_req  = 1'b1;
        mem.addr_sel = 1'b1;
        mem.mem_we   = (op_class == C_STORE);
        if (mem.mem_ready) begin
          if (op_class == C_STORE) begin
            pc_we      = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
          end else begin
            next_state = S_WB;
          end
        end
      end

      S_WB: begin
        rf_we  = rd_nz;
        pc_we  = 1'b1;
        retire = 1'b1;
        unique case (op_class)
          C_LOAD:        wb_sel = WB_MEM;
          C_JAL, C_JALR: wb_sel = WB_PC4;
          C_LUI:         wb_sel = WB_IMM;
          default:       wb_sel = WB_ALU;
        endcase
        if (op_class == C_JAL)       pc_sel = PC_IMM;
        else if (op_class == C_JALR) pc_sel = PC_ALU;
        next_state = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: next_state = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_rv32_mc_ctrl.sv
// Scoreboard bench for rv32_mc_ctrl: a per-instruction reference model pushes the
// expected per-cycle control vector; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_rv32_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ir = '0;
  logic        br_taken = 1'b0;
  logic        ir_we, ab_we, alu_a_sel, alu_b_sel, pc_we, rf_we, halted;
  logic [1:0]  pc_sel, wb_sel;
  logic [31:0] instret;
  logic        illegal_act;

  rv32_mc_ctrl_if mem_bus ();

`ifdef RV32_MC_ILLEGAL_TRAP_EN
  logic illegal;
  assign illegal_act = illegal;
`else
  assign illegal_act = 1'b0;
`endif

  rv32_mc_ctrl #(.CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem       (mem_bus.master),
    .ir        (ir),
    .br_taken  (br_taken),
    .ir_we     (ir_we),
    .ab_we     (ab_we),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .halted    (halted),
    .instret   (instret)
`ifdef RV32_MC_ILLEGAL_TRAP_EN
    ,
    .illegal   (illegal)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_we;
    logic       ab_we;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       halted;
    logic       illegal;
  } outs_t;

  typedef struct {
    outs_t       o;
    logic [31:0] cnt;
  } exp_t;

  typedef enum {K_OP, K_OPIMM, K_LUI, K_AUIPC, K_LOAD, K_STORE, K_JAL, K_JALR,
                K_BR, K_FENCE, K_SYS, K_BAD} kind_e;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  // Reference model state
  logic [31:0] cnt_m = '0;
  bit          halted_m = 1'b0;
  bit          illegal_m = 1'b0;
  logic [31:0] cur_ir = '0;

  function automatic bit rbit();
    return bit'($urandom_range(0, 1));
  endfunction

  // One clock cycle of stimulus plus the expected outputs for that cycle.
  task automatic cyc(input outs_t e, input bit ready, input bit br, input bit r);
    exp_t x;
    rst               = r;
    mem_bus.mem_ready = ready;
    br_taken          = br;
    ir                = cur_ir;
    e.halted          = halted_m;
    e.illegal         = illegal_m;
    x.o               = e;
    x.cnt             = cnt_m;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Reset issued from a state whose visible outputs are `cur`; then one RESET cycle.
  task automatic do_reset(input outs_t cur);
    cyc(cur, rbit(), rbit(), 1'b1);
    cnt_m     = '0;
    halted_m  = 1'b0;
    illegal_m = 1'b0;
    cyc('0, rbit(), rbit(), 1'b0);
  endtask

  task automatic halt_then_reset(input int n);
    for (int i = 0; i < n; i++) cyc('0, rbit(), rbit(), 1'b0);
    do_reset('0);
  endtask

  // Expected control behaviour of one instruction, from fetch to retirement.
  // abort_mem >= 0 asserts rst in that MEM wait cycle instead of completing.
  task automatic run_instr(input logic [31:0] instr, input int fw, input int mw,
                           input bit br, input int abort_mem);
    kind_e k;
    outs_t e;
    bit    to_mem, to_wb;
    case (instr[6:0])
      7'h33:   k = K_OP;
      7'h13:   k = K_OPIMM;
      7'h37:   k = K_LUI;
      7'h17:   k = K_AUIPC;
      7'h03:   k = K_LOAD;
      7'h23:   k = K_STORE;
      7'h6F:   k = K_JAL;
      7'h67:   k = K_JALR;
      7'h63:   k = K_BR;
      7'h0F:   k = K_FENCE;
      7'h73:   k = K_SYS;
      default: k = K_BAD;
    endcase

    // Fetch: waits, then the completing cycle that loads IR.
    e = '0; e.mem_req = 1'b1;
    for (int i = 0; i < fw; i++) cyc(e, 1'b0, rbit(), 1'b0);
    e.ir_we = 1'b1;
    cyc(e, 1'b1, rbit(), 1'b0);
    cur_ir = instr;

    e = '0; e.ab_we = 1'b1;
    cyc(e, rbit(), rbit(), 1'b0);

    // Execute
    e = '0; to_mem = 1'b0; to_wb = 1'b0;
    case (k)
      K_OP:              to_wb = 1'b1;
      K_OPIMM:           begin e.alu_b_sel = 1'b1; to_wb = 1'b1; end
      K_LUI:             to_wb = 1'b1;
      K_AUIPC:           begin e.alu_a_sel = 1'b1; e.alu_b_sel = 1'b1; to_wb = 1'b1; end
      K_LOAD, K_STORE:   begin e.alu_b_sel = 1'b1; to_mem = 1'b1; end
      K_JAL, K_JALR:     begin e.alu_b_sel = 1'b1; to_wb = 1'b1; end
      K_BR:              begin e.pc_we = 1'b1; e.pc_sel = br ? 2'd1 : 2'd0; end
      K_FENCE:           e.pc_we = 1'b1;
      K_SYS:             e.pc_we = (instr[14:12] != 3'd0);
      default: begin
`ifndef RV32_MC_ILLEGAL_TRAP_EN
        e.pc_we = 1'b1;
`endif
      end
    endcase
    cyc(e, rbit(), br, 1'b0);

    if (k == K_SYS && instr[14:12] == 3'd0) begin
      cnt_m    = cnt_m + 1;
      halted_m = 1'b1;
      halt_then_reset(20);
      return;
    end
    if (k == K_BAD) begin
`ifdef RV32_MC_ILLEGAL_TRAP_EN
      halted_m  = 1'b1;
      illegal_m = 1'b1;
      halt_then_reset(5);
`else
      cnt_m = cnt_m + 1;
`endif
      return;
    end
    if (!to_mem && !to_wb) begin
      cnt_m = cnt_m + 1;
      return;
    end

    if (to_mem) begin
      e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = (k == K_STORE);
      for (int i = 0; i < mw; i++) begin
        if (i == abort_mem) begin
          do_reset(e);
          return;
        end
        cyc(e, 1'b0, rbit(), 1'b0);
      end
      if (k == K_STORE) e.pc_we = 1'b1;
      cyc(e, 1'b1, rbit(), 1'b0);
      if (k == K_STORE) begin
        cnt_m = cnt_m + 1;
        return;
      end
    end

    // Writeback
    e = '0;
    e.rf_we = (instr[11:7] != 5'd0);
    e.pc_we = 1'b1;
    case (k)
      K_LOAD:        e.wb_sel = 2'd1;
      K_JAL, K_JALR: e.wb_sel = 2'd2;
      K_LUI:         e.wb_sel = 2'd3;
      default:       e.wb_sel = 2'd0;
    endcase
    e.pc_sel = (k == K_JAL) ? 2'd1 : (k == K_JALR) ? 2'd2 : 2'd0;
    cyc(e, rbit(), rbit(), 1'b0);
    cnt_m = cnt_m + 1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [12];
    logic [31:0] w;
    int          top;
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h6F, 7'h67,
             7'h63, 7'h0F, 7'h73, 7'h7F};
`ifdef RV32_MC_ILLEGAL_TRAP_EN
    top = 10;
`else
    top = 11;
`endif
    w      = $urandom;
    w[6:0] = opcs[$urandom_range(0, top)];
    if (w[6:0] == 7'h73 && w[14:12] == 3'd0) w[14:12] = 3'd1;
    if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  function automatic int rwait();
    return ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
  endfunction

  // Monitor: compares one popped expectation per cycle, away from the edge.
  initial begin
    outs_t act;
    exp_t  x;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        act = '{mem_req: mem_bus.mem_req, mem_we: mem_bus.mem_we,
                addr_sel: mem_bus.addr_sel, ir_we: ir_we, ab_we: ab_we,
                alu_a_sel: alu_a_sel, alu_b_sel: alu_b_sel, pc_we: pc_we,
                pc_sel: pc_sel, rf_we: rf_we, wb_sel: wb_sel, halted: halted,
                illegal: illegal_act};
        n_vec++;
        if (act !== x.o || instret !== x.cnt) begin
          n_err++;
          $display("FAIL vec%0d ctrl @%0t: outs got=%b want=%b instret got=%0d want=%0d",
                   n_vec, $time, act, x.o, instret, x.cnt);
        end
      end
    end
  end

  initial begin
    mem_bus.mem_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc('0, 1'b1, 1'b0, 1'b1);
    cyc('0, 1'b1, 1'b0, 1'b0);

    run_instr(32'h00500093, 0, 0, 1'b0, -1);   // addi x1,x0,5
    run_instr(32'h0000A103, 0, 3, 1'b0, -1);   // lw x2,0(x1), 3 wait cycles
    run_instr(32'h00000063, 0, 0, 1'b1, -1);   // beq taken
    run_instr(32'h00000063, 0, 0, 1'b0, -1);   // beq not taken
    run_instr(32'h00008067, 0, 0, 1'b0, -1);   // jalr x0,0(x1)
    run_instr(32'h0020A023, 1, 2, 1'b0, -1);   // sw
    run_instr(32'h000122B7, 0, 0, 1'b0, -1);   // lui
    run_instr(32'h00001317, 2, 0, 1'b0, -1);   // auipc
    run_instr(32'h008000EF, 0, 0, 1'b0, -1);   // jal x1
    run_instr(32'h0000000F, 0, 0, 1'b0, -1);   // fence
    run_instr(32'h30001073, 0, 0, 1'b0, -1);   // csrrw
    run_instr(32'h0000007F, 0, 0, 1'b0, -1);   // unknown opcode
    run_instr(32'h00500093, 0, 0, 1'b0, -1);
    run_instr(32'h0000A103, 0, 5, 1'b0, 2);    // rst mid MEM wait
    run_instr(32'h00500093, 0, 0, 1'b0, -1);

    for (int i = 0; i < 250; i++)
      run_instr(rand_instr(), rwait(), rwait(), rbit(), -1);

    run_instr(32'h00000073, 0, 0, 1'b0, -1);   // ecall, 20 halted cycles, reset
    run_instr(32'h00500093, 0, 0, 1'b0, -1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
